// File: rtl/regfile_arb_pkg.sv
// Shared types for the two-requester register-file arbiter: size defaults,
// FSM encoding, requester IDs and the round-robin pick function.
package regfile_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Sole requester wins outright; the pointer only breaks a tie.
    function automatic req_id_t rr_pick(input logic req_a, input logic req_b,
                                        input req_id_t ptr);
        req_id_t pick;
        pick = REQ_A;
        if (req_a && req_b) begin
            pick = ptr;
        end else if (req_b) begin
            pick = REQ_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational pick, pointer flips only on a
// contested grant.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_a,
    input  logic    i_req_b,
    input  logic    i_take,
    output req_id_t o_grant_c,
    output logic    o_valid_c
);

    req_id_t r_ptr;

    assign o_grant_c = rr_pick(i_req_a, i_req_b, r_ptr);
    assign o_valid_c = i_req_a | i_req_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= REQ_A;
        end else if (i_take && i_req_a && i_req_b) begin
            r_ptr <= (r_ptr == REQ_A) ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-port register file; each access
// runs IDLE -> ACCESS -> DONE with a one-cycle ack to the granted requester.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_id_t           r_gnt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_busy;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    req_id_t           w_grant;
    logic              w_valid;
    logic              w_take;
    logic              w_start;
    logic              w_finish;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_take = (r_state == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req_a   (a_req),
        .i_req_b   (b_req),
        .i_take    (w_take),
        .o_grant_c (w_grant),
        .o_valid_c (w_valid)
    );

    assign w_sel_we    = (w_grant == REQ_B) ? b_we    : a_we;
    assign w_sel_addr  = (w_grant == REQ_B) ? b_addr  : a_addr;
    assign w_sel_wdata = (w_grant == REQ_B) ? b_wdata : a_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ST_ACCESS;
                    w_start     = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_DONE;
                w_finish    = 1'b1;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant latch, register-file drive, acks and per-port read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= REQ_A;
            r_rf_we   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_a_ack <= w_finish && (r_gnt == REQ_A);
            r_b_ack <= w_finish && (r_gnt == REQ_B);
            if (w_start) begin
                r_gnt   <= w_grant;
                r_rf_we <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end else if (w_finish) begin
                r_rf_we <= 1'b0;
            end
            // r_rf_we still holds the latched op type during ACCESS.
            if (w_finish && !r_rf_we) begin
                if (r_gnt == REQ_A) begin
                    r_a_rdata <= rf_rdata;
                end else begin
                    r_b_rdata <= rf_rdata;
                end
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_addr  = r_addr;
    assign rf_wdata = r_wdata;
    assign a_ack    = r_a_ack;
    assign b_ack    = r_b_ack;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with an 8x4 register file model.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [3:0] a_rdata, b_rdata;
    logic       rf_we;
    logic [2:0] rf_addr;
    logic [3:0] rf_wdata;
    logic [3:0] rf_rdata;
    logic       busy;

    int n_chk = 0;
    int n_bad = 0;

    logic [3:0] mem [0:7];
    logic       mem_clr;
    logic [1:0] mstate;
    logic       prev_a_ack, prev_b_ack;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .busy(busy)
    );

    assign rf_rdata = mem[rf_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        end else if (rf_we) begin
            mem[rf_addr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference FSM: 0 idle, 1 access, 2 done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate <= 2'd0;
        end else begin
            case (mstate)
                2'd0:    mstate <= (a_req || b_req) ? 2'd1 : 2'd0;
                2'd1:    mstate <= 2'd2;
                default: mstate <= 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(mstate != 2'd0));
        chk("ack_in_done", 32'(a_ack | b_ack), 32'(mstate == 2'd2));
        chk("both_ack", 32'(a_ack & b_ack), 32'(0));
        chk("a_ack_width", 32'(a_ack & prev_a_ack), 32'(0));
        chk("b_ack_width", 32'(b_ack & prev_b_ack), 32'(0));
        prev_a_ack = a_ack;
        prev_b_ack = b_ack;
    end

    task automatic wait_idle();
        for (int c = 0; c < 10; c++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic do_op(input bit pb, input logic we, input logic [2:0] addr,
                         input logic [3:0] wd, input bit chg,
                         input logic [2:0] caddr, input logic [3:0] cwd);
        int lat;
        logic ack;
        wait_idle();
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk("acc_rf_we", 32'(rf_we), 32'(we));
                chk("acc_rf_addr", 32'(rf_addr), 32'(addr));
                if (we) chk("acc_rf_wdata", 32'(rf_wdata), 32'(wd));
                if (chg) begin
                    if (pb) begin b_addr = caddr; b_wdata = cwd; end
                    else    begin a_addr = caddr; a_wdata = cwd; end
                end
            end
            ack = pb ? b_ack : a_ack;
            if (ack) begin lat = c; break; end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("op_latency", 32'(lat), 32'(2));
    endtask

    task automatic contest(output int ta, output int tb);
        wait_idle();
        a_req = 1'b1;
        b_req = 1'b1;
        ta = -1;
        tb = -1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (a_ack) begin ta = c; a_req = 1'b0; end
            if (b_ack) begin tb = c; b_req = 1'b0; end
            if (ta > 0 && tb > 0) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        int ta, tb;
        rst_n = 1'b0; mem_clr = 1'b1;
        prev_a_ack = 1'b0; prev_b_ack = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ack", 32'(a_ack), 32'(0));
        chk("rst_b_ack", 32'(b_ack), 32'(0));
        chk("rst_rf_we", 32'(rf_we), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rf_addr", 32'(rf_addr), 32'(0));
        chk("rst_rf_wdata", 32'(rf_wdata), 32'(0));
        chk("rst_a_rdata", 32'(a_rdata), 32'(0));
        chk("rst_b_rdata", 32'(b_rdata), 32'(0));
        mem_clr = 1'b0;
        rst_n = 1'b1;

        // A writes 0 = A, B reads it back; A's rdata untouched
        do_op(1'b0, 1'b1, 3'd0, 4'hA, 1'b0, 3'd0, 4'h0);
        do_op(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0);
        chk("b_rd0", 32'(b_rdata), 32'(4'hA));
        chk("a_rdata_hold", 32'(a_rdata), 32'(0));

        // Contested: pointer at A -> A write 3 = 5 first, B read 3 after
        a_we = 1'b1; a_addr = 3'd3; a_wdata = 4'h5;
        b_we = 1'b0; b_addr = 3'd3; b_wdata = 4'h0;
        contest(ta, tb);
        chk("c1_a_lat", 32'(ta), 32'(2));
        chk("c1_b_lat", 32'(tb), 32'(5));
        chk("c1_b_rdata", 32'(b_rdata), 32'(4'h5));
        chk("c1_a_rdata", 32'(a_rdata), 32'(0));

        // Contested again, both read 3: pointer now at B
        a_we = 1'b0; a_addr = 3'd3;
        b_we = 1'b0; b_addr = 3'd3;
        contest(ta, tb);
        chk("c2_b_lat", 32'(tb), 32'(2));
        chk("c2_a_lat", 32'(ta), 32'(5));
        chk("c2_a_rdata", 32'(a_rdata), 32'(4'h5));
        chk("c2_b_rdata", 32'(b_rdata), 32'(4'h5));

        // Input changes during ACCESS are ignored
        do_op(1'b0, 1'b1, 3'd7, 4'hF, 1'b1, 3'd1, 4'h0);
        do_op(1'b0, 1'b0, 3'd7, 4'h0, 1'b0, 3'd0, 4'h0);
        chk("rd7", 32'(a_rdata), 32'(4'hF));
        do_op(1'b0, 1'b0, 3'd1, 4'h0, 1'b0, 3'd0, 4'h0);
        chk("rd1", 32'(a_rdata), 32'(4'h0));
        chk("b_rdata_hold", 32'(b_rdata), 32'(4'h5));

        // Reset mid-ACCESS aborts the write to addr 2
        wait_idle();
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd2; a_wdata = 4'hC;
        @(posedge clk); #1;
        chk("abort_rf_we_pre", 32'(rf_we), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rf_we", 32'(rf_we), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_rf_addr", 32'(rf_addr), 32'(0));
        a_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_a_ack", 32'(a_ack), 32'(0));
        chk("abort_mem2", 32'(mem[2]), 32'(0));
        chk("abort_b_rdata", 32'(b_rdata), 32'(0));
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_a_ack", 32'(a_ack), 32'(0));
        end
        do_op(1'b1, 1'b0, 3'd2, 4'h0, 1'b0, 3'd0, 4'h0);
        chk("rd2_after_abort", 32'(b_rdata), 32'(0));
        do_op(1'b1, 1'b0, 3'd7, 4'h0, 1'b0, 3'd0, 4'h0);
        chk("rd7_after_abort", 32'(b_rdata), 32'(4'hF));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
